lsu32: RTL and testbench

LSU32 -- requirements
Module: lsu32

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 49 ++++
 rtl/lsu32.sv | 124 ++++++++++++
 tb/tb_lsu32.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the RV32I load/store unit: funct3 codes, FSM states, fault codes.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_t;

  function automatic logic f3_legal(input logic st, input logic [2:0] f3);
    if (st) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // funct3[1:0] encodes access size for every legal code.
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return ~off[0];
      2'b10:   return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting: store strobes/replication and load lane extraction with extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_f3,
  input  logic [1:0]  st_off,
  input  logic [31:0] wdata,
  output logic [3:0]  st_strb,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_f3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] sh_b;
  logic [31:0] sh_h;

  always_comb begin
    st_strb = 4'b1111;
    st_data = wdata;
    case (st_f3)
      F3_B: begin
        st_strb = 4'b0001 << st_off;
        st_data = {4{wdata[7:0]}};
      end
      F3_H: begin
        st_strb = 4'b0011 << {st_off[1], 1'b0};
        st_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign sh_b = rdata >> {ld_off, 3'b000};
  assign sh_h = rdata >> {ld_off[1], 4'b0000};

  always_comb begin
    ld_data = rdata;
    case (ld_f3)
      F3_B:    ld_data = {{24{sh_b[7]}}, sh_b[7:0]};
      F3_H:    ld_data = {{16{sh_h[15]}}, sh_h[15:0]};
      F3_BU:   ld_data = {24'h0, sh_b[7:0]};
      F3_HU:   ld_data = {16'h0, sh_h[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu32.sv
// RV32I load/store unit: IDLE/REQ/DONE handshake FSM with fault detection and timeout.
module lsu32
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [31:0] rdata
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t        state, state_nx;
  err_t          err_r;
  logic [CW-1:0] cnt;
  logic [2:0]    ld_f3;
  logic [1:0]    ld_off;
  logic          legal, aligned, timeout;
  logic [3:0]    st_strb;
  logic [31:0]   st_data, ld_data;

  assign legal   = f3_legal(is_store, funct3);
  assign aligned = f3_aligned(funct3, addr[1:0]);
  assign timeout = (cnt == CW'(TIMEOUT_CYCLES - 1));

  lsu_align u_align (
    .st_f3   (funct3),
    .st_off  (addr[1:0]),
    .wdata   (wdata),
    .st_strb (st_strb),
    .st_data (st_data),
    .ld_f3   (ld_f3),
    .ld_off  (ld_off),
    .rdata   (mem_rdata),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = (legal && aligned) ? S_REQ : S_DONE;
      S_REQ:  if (mem_ack || timeout) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rdata     <= '0;
      err_r     <= ERR_NONE;
      cnt       <= '0;
      ld_f3     <= '0;
      ld_off    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (start) begin
            ld_f3  <= funct3;
            ld_off <= addr[1:0];
            if (!legal) begin
              err_r <= ERR_ILLEGAL;
            end else if (!aligned) begin
              err_r <= ERR_MISALIGN;
            end else begin
              err_r     <= ERR_NONE;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= st_data;
              mem_wstrb <= is_store ? st_strb : 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata <= ld_data;
          end else if (timeout) begin
            mem_req <= 1'b0;
            err_r   <= ERR_TIMEOUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);
  assign err      = done && (err_r != ERR_NONE);
  assign err_code = err_r;

endmodule

// File: tb/tb_lsu32.sv
// Randomized scoreboard bench for lsu32 with a behavioural memory and reference model.
module tb_lsu32;

  logic        clk = 1'b0;
  logic        reset, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, busy, done, err;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  err_code;

  lsu32 #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .rdata(rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [1:0]  code;
    logic [31:0] rdata;
    int          lat;
    int          t0;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  strb;
  } req_t;

  done_t       dq[$];
  req_t        rq[$];
  req_t        cur;
  logic        prev_req = 1'b0;
  logic        mon_en = 1'b0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          plan_delay = 0;
  int          req_cyc = 0;
  logic [31:0] plan_word = '0;
  logic [31:0] exp_rdata = '0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory: acks on REQ cycle plan_delay; spurious acks with junk data while idle.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req) begin
      if (req_cyc == plan_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = plan_word;
      end
      req_cyc++;
    end else begin
      req_cyc   = 0;
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_req) begin
        if (!prev_req) begin
          if (rq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_req: got mem_req=1 expected no request");
          end else begin
            cur = rq.pop_front();
          end
        end
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(cur.strb));
        if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
      end
      prev_req = mem_req;
      if (done) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no completion");
        end else begin
          done_t e;
          e = dq.pop_front();
          chk("err", 32'(err), 32'(e.err));
          chk("err_code", 32'(err_code), 32'(e.code));
          chk("rdata", rdata, e.rdata);
          chk("latency", 32'(cyc - e.t0), 32'(e.lat));
          chk("mem_req_in_done", 32'(mem_req), 32'd0);
        end
      end
    end
  end

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input int off, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * off);
    case (f3)
      3'd0: return (s[7:0] >= 8'd128) ? (32'(s[7:0]) | 32'hFFFF_FF00) : 32'(s[7:0]);
      3'd1: return (s[15:0] >= 16'd32768) ? (32'(s[15:0]) | 32'hFFFF_0000) : 32'(s[15:0]);
      3'd4: return 32'(s[7:0]);
      3'd5: return 32'(s[15:0]);
      default: return w;
    endcase
  endfunction

  task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input logic [31:0] word, input int delay,
                    input bit poke);
    done_t e;
    req_t  r;
    bit    legal;
    int    size, off;
    off   = int'(a % 4);
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << (f3 % 4);
    e.t0  = cyc;
    e.rdata = exp_rdata;
    if (!legal) begin
      e.err = 1'b1; e.code = 2'b10; e.lat = 1;
    end else if (off % size != 0) begin
      e.err = 1'b1; e.code = 2'b01; e.lat = 1;
    end else begin
      r.addr = a - 32'(off);
      r.we   = st;
      if (!st) begin
        r.strb = 4'b0000; r.wdata = '0;
      end else if (f3 == 3'd0) begin
        r.strb = 4'(1 << off); r.wdata = (wd % 256) * 32'h0101_0101;
      end else if (f3 == 3'd1) begin
        r.strb = 4'(3 << off); r.wdata = (wd % 65536) * 32'h0001_0001;
      end else begin
        r.strb = 4'b1111; r.wdata = wd;
      end
      rq.push_back(r);
      if (delay < 4) begin
        e.err = 1'b0; e.code = 2'b00; e.lat = delay + 2;
        if (!st) begin
          exp_rdata = ld_model(f3, off, word);
          e.rdata   = exp_rdata;
        end
      end else begin
        e.err = 1'b1; e.code = 2'b11; e.lat = 4 + 1;
      end
    end
    dq.push_back(e);
    plan_delay = delay;
    plan_word  = word;
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom; is_store = 1'($urandom);
    if (poke) begin
      start = 1'b1; funct3 = 3'b011;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    if (busy) chk("busy_wait_bound", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    op(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    op(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF_FF7F, 1, 1'b0);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);
    op(1'b0, 3'd4, 32'h203, 32'h0, 32'h80FF_FF7F, 0, 1'b0);
    chk("lbu_rdata", rdata, 32'h0000_0080);
    op(1'b1, 3'd1, 32'h302, 32'h1234ABCD, 32'h0, 2, 1'b0);
    op(1'b0, 3'd2, 32'h101, 32'h0, 32'h0, 0, 1'b0);
    op(1'b0, 3'd2, 32'h400, 32'h0, 32'h0, 99, 1'b0);
    op(1'b0, 3'd5, 32'h502, 32'h0, 32'h1234_8765, 3, 1'b1);

    // Retry that is cut short by reset mid-REQ.
    begin
      req_t r;
      r.addr = 32'h600; r.we = 1'b0; r.strb = 4'b0000; r.wdata = '0;
      rq.push_back(r);
      plan_delay = 99;
      start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h600;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_rdata", rdata, 32'd0);
      reset = 1'b0;
      exp_rdata = '0;
      @(negedge clk);
    end

    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      a = {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) a = a & ~32'd3;
      op(1'($urandom), 3'($urandom), a, $urandom, $urandom, $urandom_range(0, 5),
         $urandom_range(0, 7) == 0);
    end

    repeat (3) @(negedge clk);
    chk("done_queue_empty", 32'(dq.size()), 32'd0);
    chk("req_queue_empty", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
